// File: rtl/csa_pipe_addsub.sv
// csa_pipe_addsub: pipelined carry-select add/subtract.
// WIDTH bits are split into STAGES slices of SEG bits. Each stage resolves one
// slice and registers its carry for the next stage.
// Optional feature: define CSA_PIPE_SATURATE_EN to clamp Sum on signed overflow.

// One carry-select slice: both candidate sums are formed, and the incoming carry picks one.
module csa_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cmsb
);
    logic [SEG:0] sum0, sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    assign {co, s} = ci ? sum1 : sum0;
    // The carry into the top bit is recovered from that bit's own sum.
    assign cmsb = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];
endmodule

module csa_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);
    localparam int SEG = WIDTH / STAGES;

    logic                          adv, acc;
    logic [STAGES:1]               vld_q;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0]  a_i, b_i, s_i, s_d;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
    logic [STAGES-1:0]             c_i, c_d, c_q, cmsb;
    logic [WIDTH-1:0]              sum_fin;
    logic                          ovf_d, ovf_q;
    logic                          unused_ok;

    // The whole pipe advances together, or freezes when the output is blocked.
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign acc       = in_valid & adv;
    assign out_valid = vld_q[STAGES];

    // Valid shift chain: bit 0 is the beat being accepted now.
    always_comb vld_pipe = {vld_q, acc};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [SEG-1:0]   seg_s;
        logic             seg_co;
        logic [WIDTH-1:0] s_nx;

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1, so the operand is inverted and the carry forced.
            assign a_i[k] = A;
            assign b_i[k] = Sub ? ~B : B;
            assign s_i[k] = '0;
            assign c_i[k] = Sub | Cin;
        end else begin : g_chain
            assign a_i[k] = a_q[k-1];
            assign b_i[k] = b_q[k-1];
            assign s_i[k] = s_q[k-1];
            assign c_i[k] = c_q[k-1];
        end

        csa_seg #(.SEG(SEG)) u_seg (
            .a    (a_i[k][k*SEG +: SEG]),
            .b    (b_i[k][k*SEG +: SEG]),
            .ci   (c_i[k]),
            .s    (seg_s),
            .co   (seg_co),
            .cmsb (cmsb[k])
        );

        // Merge this slice into the partial sum carried down the pipe.
        always_comb begin
            s_nx = s_i[k];
            s_nx[k*SEG +: SEG] = seg_s;
        end

        assign s_d[k] = s_nx;
        assign c_d[k] = seg_co;
    end

    assign ovf_d = cmsb[STAGES-1] ^ c_d[STAGES-1];

`ifdef CSA_PIPE_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    // On overflow both effective operands share a sign; clamp toward that sign.
    always_comb begin
        sum_fin = s_d[STAGES-1];
        if (ovf_d) sum_fin = a_i[STAGES-1][WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`else
    assign sum_fin = s_d[STAGES-1];
`endif

    // Stage registers: clear on reset, load all stages together on advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            vld_q           <= vld_pipe[STAGES-1:0];
            a_q             <= a_i;
            b_q             <= b_i;
            s_q             <= s_d;
            s_q[STAGES-1]   <= sum_fin;
            c_q             <= c_d;
            ovf_q           <= ovf_d;
        end
    end

    assign Sum      = s_q[STAGES-1];
    assign Cout     = c_q[STAGES-1];
    assign Overflow = ovf_q;

    // The last stage's forwarded operands and the inner slice MSB carries have no consumer.
    assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], cmsb, vld_pipe[STAGES]};
endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Bench for csa_pipe_addsub: directed plan steps plus randomized traffic
// against a signed-arithmetic reference model and an in-order expectation queue.
module tb_csa_pipe_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        v16, ir16, ov16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        v8, ir8, ov8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        zero = 1'b0, one = 1'b1;

    int tests = 0;
    int fails = 0;
    logic [33:0] exp_q[$];

    csa_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .Sum(sum), .Cout(cout), .Overflow(ovf));

    csa_pipe_addsub #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16),
        .A(a16), .B(b16), .Cin(zero), .Sub(zero), .out_valid(ov16),
        .out_ready(one), .Sum(s16), .Cout(co16), .Overflow(of16));

    csa_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
        .A(a8), .B(b8), .Cin(zero), .Sub(zero), .out_valid(ov8),
        .out_ready(one), .Sum(s8), .Cout(co8), .Overflow(of8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits; overflow = result out of 32-bit range.
    function automatic logic [33:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [31:0] yy;
        logic        c;
        logic [32:0] u;
        longint      sr;
        logic        o;
        logic [31:0] r;
        yy = s ? ~y : y;
        c  = s ? 1'b1 : ci;
        u  = {1'b0, x} + {1'b0, yy} + {32'd0, c};
        sr = longint'($signed(x)) + longint'($signed(yy)) + longint'(c);
        o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r  = u[31:0];
`ifdef CSA_PIPE_SATURATE_EN
        if (o) r = (sr < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {o, u[32], r};
    endfunction

    // Record every accepted beat; a reset drops everything in flight.
    always @(posedge clk) begin
        if (!rst_n) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(ref32(a, b, cin, sub));
    end

    // Every valid output must match the oldest outstanding beat, held or consumed.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", out_valid, 1'b0);
            else begin
                chk("out_result", {ovf, cout, sum}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        int n = 0;
        in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("send_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1 chk("drain_empty", exp_q.size(), 0);
        @(negedge clk) chk("drain_idle", out_valid, 1'b0);
        tick();
    endtask

    initial begin
        logic [31:0] t1_exp, t2_first, t4_exp;
        logic [7:0]  t6_exp8;
        t1_exp = 32'hFFFF_FFFE; t2_first = 32'h7FFF_FFFF; t6_exp8 = 8'h80;
`ifdef CSA_PIPE_SATURATE_EN
        t1_exp = 32'h7FFF_FFFF; t2_first = 32'h8000_0000; t6_exp8 = 8'h7F;
`endif
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; v8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_valid16", ov16, 1'b0);
        tick(); rst_n = 1'b1;

        // 1: positive overflow, latency 4
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk) chk("t1_latency", out_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_sum", sum, t1_exp);
        chk("t1_cout", cout, 1'b0);
        chk("t1_ovf", ovf, 1'b1);
        tick();
        wait_drain();

        // 2: back-to-back beats, results on consecutive cycles in order
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h1234_5670, 1'b1, 1'b0);
        send(32'hFFFF_F999, 32'h0000_0111, 1'b0, 1'b0);
        @(negedge clk) chk("t2_pre", out_valid, 1'b0);
        @(negedge clk) chk("t2_sum0", {out_valid, ovf, cout, sum}, {3'b111, t2_first});
        @(negedge clk) chk("t2_sum1", {out_valid, ovf, cout, sum}, {3'b100, 32'h2468_ACE9});
        @(negedge clk) chk("t2_sum2", {out_valid, ovf, cout, sum}, {3'b100, 32'hFFFF_FAAA});
        @(negedge clk) chk("t2_post", out_valid, 1'b0);
        tick();

        // 3: subtract mode
        send(32'h0000_0420, 32'h0000_0421, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait_drain();

        // 4: backpressure fills and freezes the pipe
        out_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        send(32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0);
        send(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1);
        t4_exp = 32'h0000_0003;
        repeat (3) begin
            @(negedge clk);
            chk("t4_in_ready", in_ready, 1'b0);
            chk("t4_hold", {out_valid, sum}, {1'b1, t4_exp});
        end
        tick();
        in_valid = 1'b1; a = 32'hDEAD_0000; b = 32'h0000_BEEF; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        @(negedge clk) chk("t4_pending", exp_q.size(), 4);
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_drain();

        // 5: reset with three beats in flight
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
        send(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst", {out_valid, ovf, cout, sum}, 35'h0);
        send(32'h0000_0123, 32'h0000_0123, 1'b0, 1'b0);
        repeat (3) @(negedge clk) chk("t5_no_stale", out_valid, 1'b0);
        @(negedge clk) chk("t5_sum", {out_valid, sum}, {1'b1, 32'h0000_0246});
        tick();
        wait_drain();

        // 6: parameter sweep instances
        a16 = 16'hFFFF; b16 = 16'h0001; v16 = 1'b1;
        a8 = 8'h7F; b8 = 8'h01; v8 = 1'b1;
        tick();
        v16 = 1'b0; v8 = 1'b0;
        @(negedge clk);
        chk("t6_w8", {ov8, of8, co8, s8}, {3'b110, t6_exp8});
        chk("t6_w16_lat", ov16, 1'b0);
        @(negedge clk);
        chk("t6_w16", {ov16, of16, co16, s16}, {3'b101, 16'h0000});
        chk("t6_w8_once", ov8, 1'b0);
        tick();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = (i % 17 == 0) ? 32'h7FFF_FFFF : $urandom;
            b   = (i % 13 == 0) ? 32'h8000_0000 : $urandom;
            cin = $urandom_range(0, 1);
            sub = $urandom_range(0, 1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
